seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the Basys 3 four-digit common-anode 7-segment display.
- Consumes the four 4-bit digit values (A leftmost … D rightmost) produced by the mode/input selection logic.
- Captures them once per frame, decodes each to hex glyphs and scans the anodes with a dead-time gap between digits to prevent ghosting.
- Sits between the input-select datapath and the board pins: seg, dp, an.

Parameters:
- DIGIT_CYCLES, 100000: clock cycles each digit is lit (1 ms at 100 MHz); must be >= 1.
- BLANK_CYCLES, 1000: clock cycles of all-anodes-off dead time before each digit; must be >= 1.

Ports:
- clk  input  1  system clock, 100 MHz on board.
- reset  input  1  synchronous, active-high reset.
- en  input  1  display enable; low forces the display dark.
- A  input  4  leftmost digit value (drives an[3]).
- B  input  4  digit value (drives an[2]).
- C  input  4  digit value (drives an[1]).
- D  input  4  rightmost digit value (drives an[0]).
- dp_in  input  4  decimal-point request per digit; bit 3 = A … bit 0 = D; 1 = lit.
- lz_blank  input  1  1 = suppress leading zeros.
- seg  output  7  cathodes, active-low; seg[0]=a … seg[6]=g.
- dp  output  1  decimal-point cathode, active-low.
- an  output  4  anodes, active-low; an[3]=A … an[0]=D.
- frame_tick  output  1  one-cycle pulse at the end of each complete frame.

Behaviour:
- One clock, clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: an=4'b1111, seg=7'h7F, dp=1, frame_tick=0. State=IDLE, digit index=A, counter=0, snapshot=0.
- States:
  - IDLE: all outputs off.
  - BLANK: an=1111, seg=7F, dp=1, for BLANK_CYCLES.
  - SHOW: selected anode low, glyph driven, for DIGIT_CYCLES.
- Transitions:
  - IDLE→BLANK(A) on the first edge with reset=0 and en=1. That same edge loads the snapshot of A, B, C, D, dp_in and lz_blank.
  - BLANK→SHOW after BLANK_CYCLES.
  - SHOW→BLANK(next digit) after DIGIT_CYCLES. Scan order is A, B, C, D.
  - After SHOW(D), go to BLANK(A) and reload the snapshot on that edge.
- Frame length = 4*(BLANK_CYCLES+DIGIT_CYCLES) cycles.
- frame_tick=1 only during the last SHOW cycle of digit D.
- Snapshot rule: inputs are sampled only at frame start. Mid-frame input changes are never visible until the next frame (no tearing).
- Glyph encoding, seg[6:0] active-low (gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (snapshot lz_blank=1):
  - Digit A, B or C is blanked if it and every more-significant digit are 0.
  - D is never blanked.
  - A blanked digit keeps its anode slot active with seg=7F.
  - dp still follows dp_in for a blanked digit.
- dp = ~dp_in_snapshot[digit] during SHOW; dp=1 otherwise.
- en low at any time:
  - Next edge enters IDLE with all outputs off, counter cleared, frame_tick=0.
  - On en rising, restart at BLANK(A) with a fresh snapshot.
- reset mid-frame has the same effect as reset at power-up. Reset has priority over en.
- Counters are sized for max(DIGIT_CYCLES, BLANK_CYCLES) and wrap only via explicit reload, never by overflow.

Test Plan (DIGIT_CYCLES=4, BLANK_CYCLES=2, frame=24 cycles; cycle 0 = first edge after reset release with en=1):
- Basic scan: A..D=6,4,9,6, dp_in=0, lz_blank=0.
  - Cycles 0-1: an=1111.
  - Cycles 2-5: an=0111, seg=02.
  - Cycles 8-11: an=1011, seg=19.
  - Cycles 14-17: an=1101, seg=10.
  - Cycles 20-23: an=1110, seg=02.
  - frame_tick=1 only at cycle 23.
- Leading zeros: lz_blank=1, A..D=0,0,0,5.
  - A, B and C slots: seg=7F.
  - D slot: seg=12.
  - With A..D=0,0,0,0, D slot shows seg=40.
  - With A..D=0,3,0,0, A slot is 7F; B=30, C=40, D=40.
- Snapshot integrity: change A from 6 to F at cycle 10.
  - Current frame keeps A=seg 02.
  - Next frame A slot (cycles 26-29) shows seg=0E.
- Enable/reset mid-frame:
  - en=0 at cycle 9: from the next edge, an=1111, seg=7F, dp=1, no frame_tick.
  - en=1 again: restart with 2 blank cycles, then digit A.
  - Repeat the sequence using reset=1 instead of en=0.
- Decoder sweep: D stepped through 0..F, one value per frame; each D slot matches the glyph list.
- Decimal point: dp_in=4'b1010.
  - dp=0 only during A and C SHOW windows.
  - dp=1 during every BLANK window.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Digit/control inputs and board-pin outputs of the 4-digit 7-segment scan driver.
// The driver takes the slave modport; the digit source and pin side take master.
interface seg7_scan_driver_if;
  logic       en;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] C;
  logic [3:0] D;
  logic [3:0] dp_in;
  logic       lz_blank;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output en, A, B, C, D, dp_in, lz_blank,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  en, A, B, C, D, dp_in, lz_blank,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: per-frame input snapshot,
// hex decode, leading-zero blanking and a dead-time gap before every digit.
module seg7_scan_driver #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input logic            clk,
  input logic            reset,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_D = 2'd3;

  logic [1:0]       state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      snap_val, snap_val_n;   // {A,B,C,D}
  logic [3:0]       snap_dp, snap_dp_n;
  logic             snap_lz, snap_lz_n;

  logic [6:0] seg_q, seg_n;
  logic       dp_q, dp_n;
  logic [3:0] an_q, an_n;
  logic       tick_q, tick_n;

  logic       load;
  logic [3:0] digit;
  logic       lz_a, lz_b, lz_c, blanked;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // Next-state logic and next values of the registered pin outputs.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt;
    load       = 1'b0;
    snap_val_n = snap_val;
    snap_dp_n  = snap_dp;
    snap_lz_n  = snap_lz;
    seg_n      = 7'h7F;
    dp_n       = 1'b1;
    an_n       = 4'b1111;
    tick_n     = 1'b0;
    digit      = 4'h0;
    lz_a       = 1'b0;
    lz_b       = 1'b0;
    lz_c       = 1'b0;
    blanked    = 1'b0;

    if (!bus.en) begin
      state_n = IDLE;
      idx_n   = IDX_A;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          idx_n   = IDX_A;
          cnt_n   = '0;
          load    = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt == DIGIT_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            if (idx == IDX_D) begin
              idx_n = IDX_A;
              load  = 1'b1;
            end else begin
              idx_n = idx + 2'd1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = IDX_A;
          cnt_n   = '0;
        end
      endcase
    end

    if (load) begin
      snap_val_n = {bus.A, bus.B, bus.C, bus.D};
      snap_dp_n  = bus.dp_in;
      snap_lz_n  = bus.lz_blank;
    end

    // A leading zero is blanked only while every more-significant digit is also zero.
    lz_a = snap_lz_n && (snap_val_n[15:12] == 4'h0);
    lz_b = lz_a && (snap_val_n[11:8] == 4'h0);
    lz_c = lz_b && (snap_val_n[7:4] == 4'h0);

    if (state_n == SHOW) begin
      case (idx_n)
        2'd0: begin an_n = 4'b0111; digit = snap_val_n[15:12]; blanked = lz_a; dp_n = ~snap_dp_n[3]; end
        2'd1: begin an_n = 4'b1011; digit = snap_val_n[11:8];  blanked = lz_b; dp_n = ~snap_dp_n[2]; end
        2'd2: begin an_n = 4'b1101; digit = snap_val_n[7:4];   blanked = lz_c; dp_n = ~snap_dp_n[1]; end
        default: begin an_n = 4'b1110; digit = snap_val_n[3:0]; blanked = 1'b0; dp_n = ~snap_dp_n[0]; end
      endcase
      seg_n  = blanked ? 7'h7F : glyph(digit);
      tick_n = (idx_n == IDX_D) && (cnt_n == DIGIT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= IDX_A;
      cnt      <= '0;
      snap_val <= '0;
      snap_dp  <= '0;
      snap_lz  <= 1'b0;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      an_q     <= 4'b1111;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      snap_val <= snap_val_n;
      snap_dp  <= snap_dp_n;
      snap_lz  <= snap_lz_n;
      seg_q    <= seg_n;
      dp_q     <= dp_n;
      an_q     <= an_n;
      tick_q   <= tick_n;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-position reference model predicts
// every cycle's pins; a monitor compares them one cycle after each edge.
module tb_seg7_scan_driver;

  localparam int DC    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  seg7_scan_driver_if bus();

  seg7_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // Stimulus values (A..D as index 0..3) applied on the next cycle.
  logic [3:0] dig_v [4];
  logic [3:0] dp_v;
  logic       lz_v, en_v, rst_v;

  // Reference model state: whether a frame is running, position in it, and the frame's snapshot.
  bit         running;
  int         pos;
  logic [3:0] snap_d [4];
  logic [3:0] snap_dp;
  bit         snap_lz;

  task automatic model_step();
    exp_t e;
    int   slot, off;
    bit   lead;
    if (rst_v || !en_v) begin
      running = 0;
    end else begin
      if (!running) begin
        running = 1;
        pos     = 0;
      end else begin
        pos = pos + 1;
        if (pos == FRAME) pos = 0;
      end
      if (pos == 0) begin
        for (int i = 0; i < 4; i++) snap_d[i] = dig_v[i];
        snap_dp = dp_v;
        snap_lz = lz_v;
      end
    end
    e = '{an: 4'b1111, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
    if (running) begin
      slot = pos / SLOT;
      off  = pos % SLOT;
      if (off >= BC) begin
        e.an = 4'b1111;
        e.an[3 - slot] = 1'b0;
        lead = snap_lz && (slot < 3);
        for (int i = 0; i <= slot; i++) if (snap_d[i] != 4'h0) lead = 0;
        e.seg = lead ? 7'h7F : glyph_tbl[snap_d[slot]];
        e.dp  = ~snap_dp[3 - slot];
        e.ft  = (slot == 3) && (off == SLOT - 1);
      end
    end
    q.push_back(e);
  endtask

  // Drive one cycle's inputs just after a falling edge and queue the expected pins.
  task automatic cyc();
    reset        = rst_v;
    bus.en       = en_v;
    bus.A        = dig_v[0];
    bus.B        = dig_v[1];
    bus.C        = dig_v[2];
    bus.D        = dig_v[3];
    bus.dp_in    = dp_v;
    bus.lz_blank = lz_v;
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    dig_v[0] = a; dig_v[1] = b; dig_v[2] = c; dig_v[3] = d;
  endtask

  // Monitor: one comparison per cycle once an expectation is queued.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_tick} === e) begin
        passes++;
      end else begin
        $display("FAIL pins t=%0t an=%b seg=%h dp=%b ft=%b expected an=%b seg=%h dp=%b ft=%b",
                 $time, bus.an, bus.seg, bus.dp, bus.frame_tick, e.an, e.seg, e.dp, e.ft);
      end
    end
  end

  initial begin
    running = 0; pos = 0; snap_lz = 0; snap_dp = '0;
    for (int i = 0; i < 4; i++) snap_d[i] = '0;
    rst_v = 1; en_v = 1; dp_v = '0; lz_v = 0;
    set_digits(4'h6, 4'h4, 4'h9, 4'h6);
    reset = 1'b1;
    bus.en = 1'b0; bus.A = '0; bus.B = '0; bus.C = '0; bus.D = '0;
    bus.dp_in = '0; bus.lz_blank = 1'b0;
    @(negedge clk);
    run(3);

    // Basic scan, then A changes mid-frame and must only appear next frame.
    rst_v = 0;
    run(10);
    dig_v[0] = 4'hF;
    run(2 * FRAME - 10);

    // Leading-zero blanking patterns.
    lz_v = 1;
    set_digits(4'h0, 4'h0, 4'h0, 4'h5); run(FRAME);
    set_digits(4'h0, 4'h0, 4'h0, 4'h0); run(FRAME);
    set_digits(4'h0, 4'h3, 4'h0, 4'h0); run(FRAME);
    lz_v = 0;

    // Enable drop mid-frame and restart, then the same with reset.
    run(9); en_v = 0; run(5); en_v = 1; run(FRAME);
    run(9); rst_v = 1; run(3); rst_v = 0; run(FRAME);

    // Decoder sweep on D, one value per frame, aligned to a fresh start.
    en_v = 0; cyc(); en_v = 1;
    for (int v = 0; v < 16; v++) begin
      set_digits(4'h1, 4'h2, 4'h3, 4'(v));
      run(FRAME);
    end

    // Decimal points on A and C.
    dp_v = 4'b1010; run(2 * FRAME);

    // Randomized traffic with occasional enable drops and resets.
    for (int n = 0; n < 1500; n++) begin
      rst_v = ($urandom_range(0, 199) == 0);
      if (!en_v) en_v = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 99) == 0) en_v = 0;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 15) == 0)
          dig_v[i] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) dp_v = 4'($urandom);
      if ($urandom_range(0, 63) == 0) lz_v = ~lz_v;
      cyc();
    end

    rst_v = 0; en_v = 1;
    run(2);
    @(posedge clk); #2;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain leftover=%0d expected 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
